// File: rtl/clk_divider_prog_if.sv
// Configuration and output bundle of the programmable Fg/Dac clock divider.
// The bench drives through master; the divider sits on slave.
interface clk_divider_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] half_div;
  logic [DIV_W:0]   phase;
  logic             cfg_load;
  logic             Fg_CLK;
  logic             Dac_CLK;
  logic             period_tick;
  logic             cfg_busy;
  logic             cfg_err;

  modport master (
    output en, half_div, phase, cfg_load,
    input  Fg_CLK, Dac_CLK, period_tick, cfg_busy, cfg_err
  );

  modport slave (
    input  en, half_div, phase, cfg_load,
    output Fg_CLK, Dac_CLK, period_tick, cfg_busy, cfg_err
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable 50%-duty clock divider producing Fg_CLK and a phase-delayed Dac_CLK.
// New ratios are shadowed and applied only at terminal count, so switches never create runts.
module clk_divider_prog #(
  parameter int DIV_W     = 8,
  parameter int DEF_HALF  = 1,
  parameter int DEF_PHASE = 1
) (
  input  logic               PLL_CLK,
  input  logic               RESETn,
  clk_divider_prog_if.slave  div_if
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [DIV_W-1:0] DEF_H    = DEF_HALF[DIV_W-1:0];
  localparam logic [DIV_W:0]   DEF_PH   = DEF_PHASE[DIV_W:0];
  localparam logic [DIV_W:0]   CNT_ZERO = {(DIV_W+1){1'b0}};
  localparam logic [DIV_W:0]   CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [DIV_W:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d, sh_half_q, sh_half_d;
  logic [DIV_W:0]   ph_q, ph_d, sh_ph_q, sh_ph_d;
  logic             busy_q, busy_d;
  logic             fg_q, fg_d, dac_q, dac_d, tick_q, tick_d, err_q, err_d;

  logic [DIV_W:0]   two_h_s, req_two_h_s, dac_cnt_s;
  logic             tc_s, active_s, cfg_ok_s, cfg_acc_s;

  // Period length is kept one bit wider than H so H = 2^DIV_W-1 does not overflow.
  assign two_h_s     = {half_q, 1'b0};
  assign req_two_h_s = {div_if.half_div, 1'b0};
  assign tc_s        = (cnt_q == (two_h_s - CNT_ONE));
  assign active_s    = (state_q != IDLE);
  assign cfg_ok_s    = (div_if.half_div != {DIV_W{1'b0}}) && (div_if.phase < req_two_h_s);
  assign cfg_acc_s   = div_if.cfg_load && cfg_ok_s;
  assign dac_cnt_s   = (cnt_q >= ph_q) ? (cnt_q - ph_q) : (cnt_q + two_h_s - ph_q);

  // Next-state: run/stop sequencing, counter, configuration shadowing and outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    ph_d      = ph_q;
    sh_half_d = sh_half_q;
    sh_ph_d   = sh_ph_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (div_if.en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = tc_s ? CNT_ZERO : (cnt_q + CNT_ONE);
        if (!div_if.en) begin
          state_d = STOP;
        end else begin
          state_d = RUN;
        end
      end
      STOP: begin
        cnt_d = tc_s ? CNT_ZERO : (cnt_q + CNT_ONE);
        if (div_if.en) begin
          state_d = RUN;
        end else if (tc_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Pending ratio goes live on the period boundary; a load on that same edge waits for the next one.
    if (active_s && tc_s && busy_q) begin
      half_d = sh_half_q;
      ph_d   = sh_ph_q;
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    if (cfg_acc_s) begin
      sh_half_d = div_if.half_div;
      sh_ph_d   = div_if.phase;
      if (state_q == IDLE) begin
        half_d = div_if.half_div;
        ph_d   = div_if.phase;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      sh_half_d = sh_half_q;
      sh_ph_d   = sh_ph_q;
    end

    fg_d   = active_s && (cnt_q >= {1'b0, half_q});
    dac_d  = active_s && (dac_cnt_s >= {1'b0, half_q});
    tick_d = active_s && tc_s;
    err_d  = div_if.cfg_load && !cfg_ok_s;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      half_q    <= DEF_H;
      ph_q      <= DEF_PH;
      sh_half_q <= DEF_H;
      sh_ph_q   <= DEF_PH;
      busy_q    <= 1'b0;
      fg_q      <= 1'b0;
      dac_q     <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      ph_q      <= ph_d;
      sh_half_q <= sh_half_d;
      sh_ph_q   <= sh_ph_d;
      busy_q    <= busy_d;
      fg_q      <= fg_d;
      dac_q     <= dac_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign div_if.Fg_CLK      = fg_q;
  assign div_if.Dac_CLK     = dac_q;
  assign div_if.period_tick = tick_q;
  assign div_if.cfg_busy    = busy_q;
  assign div_if.cfg_err     = err_q;

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter DIV_W, default 8: width of the half-period count.
REQ-002 Parameter DEF_HALF, default 1: half-period H applied at reset.
REQ-003 Parameter DEF_PHASE, default 1: Dac phase offset PH applied at reset.
REQ-004 PLL_CLK  in  1  clock; all state SHALL update on the rising edge.
REQ-005 RESETn  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  run request, level.
REQ-007 half_div  in  DIV_W  requested half-period H, in PLL_CLK cycles.
REQ-008 phase  in  DIV_W+1  requested Dac offset PH, in PLL_CLK cycles.
REQ-009 cfg_load  in  1  one-cycle strobe that samples half_div and phase.
REQ-010 Fg_CLK  out  1  generator clock, period 2H, 50% duty.
REQ-011 Dac_CLK  out  1  Fg_CLK shifted late by PH cycles.
REQ-012 period_tick  out  1  one-cycle pulse on the last cycle of each output period.
REQ-013 cfg_busy  out  1  high while a sampled configuration waits to be applied.
REQ-014 cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-015 The block SHALL hold active registers H and PH, shadow registers, and a counter cnt with range 0..2H-1.
REQ-016 States: IDLE, RUN, STOP. IDLE -> RUN when en=1 (cnt=0). RUN -> STOP when en=0. STOP -> IDLE at terminal count (cnt=2H-1). STOP -> RUN when en=1 again; cnt continues without restart.
REQ-017 In RUN and STOP, cnt SHALL increment each cycle and wrap from 2H-1 to 0. In IDLE, cnt SHALL be 0.
REQ-018 Fg_CLK SHALL be registered: Fg_CLK <= (state!=IDLE) and (cnt >= H). This gives one cycle of latency from cnt.
REQ-019 Dac_CLK SHALL be registered: d = (cnt>=PH) ? cnt-PH : cnt+2H-PH; Dac_CLK <= (state!=IDLE) and (d >= H). With PH=0, Dac_CLK equals Fg_CLK. With PH=H, Dac_CLK equals the inverse of Fg_CLK.
REQ-020 Both outputs SHALL be 0 in IDLE. Entering IDLE only at terminal count guarantees no runt pulse.
REQ-021 period_tick SHALL be registered high for the cycle after cnt=2H-1 is observed in RUN or STOP.
REQ-022 cfg_load SHALL be rejected, with a cfg_err pulse and the shadow unchanged, when half_div=0 or phase >= 2*half_div.
REQ-023 An accepted cfg_load SHALL load the shadow registers and set cfg_busy=1. A later accepted cfg_load SHALL overwrite the shadow (last one wins).
REQ-024 In RUN or STOP, the shadow SHALL be copied to H/PH at terminal count, with cnt going to 0 and cfg_busy to 0 on the same edge. Ratio changes are therefore glitch-free and period-aligned.
REQ-025 A cfg_load in the same cycle as terminal count SHALL take effect at the following terminal count, not the current one.
REQ-026 In IDLE, an accepted cfg_load SHALL update H/PH on the next edge, and cfg_busy SHALL stay 0.
REQ-027 2H SHALL be computed at DIV_W+1 bits. H=2^DIV_W-1 SHALL work without overflow.

Reset
REQ-028 RESETn=0 SHALL force asynchronously: state=IDLE, cnt=0, H=DEF_HALF, PH=DEF_PHASE, shadow=defaults, and Fg_CLK, Dac_CLK, period_tick, cfg_busy, cfg_err all 0.
REQ-029 Reset asserted mid-period SHALL discard any pending configuration. After release the block SHALL wait for en.

Verification
REQ-030 Reset release, en=1, defaults (H=1, PH=1) -> Fg_CLK toggles every cycle (period 2). Dac_CLK is the inverse of Fg_CLK. period_tick pulses every 2 cycles.
REQ-031 cfg_load with half_div=3, phase=0 while running -> cfg_busy=1 until terminal count. Then Fg period 6 (3 high/3 low), Dac_CLK == Fg_CLK, and no pulse shorter than 1 cycle at the switch.
REQ-032 half_div=4, phase=2 -> Dac_CLK rises exactly 2 PLL_CLK cycles after each Fg_CLK rise, both period 8.
REQ-033 cfg_load with half_div=0, then with half_div=2, phase=4 -> two cfg_err pulses, active H/PH unchanged, cfg_busy stays 0.
REQ-034 Drop en mid-period with H=5 -> outputs finish the current 10-cycle period and then park at 0. Raising en during STOP continues the period without restart.
REQ-035 Assert RESETn=0 while cfg_busy=1 -> all outputs 0 immediately. After release with en=1, defaults are active (period 2).
